instr_exec: RTL and testbench

//  Mode-1 execute stage. Consumes the 8-bit instr from the PC/ROM stage, runs
//  a multi-cycle fetch/decode/execute FSM on an accumulator datapath, and

---
 rtl/instr_exec.sv | 203 ++++++++++++++++++++
 tb/tb_instr_exec.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_exec.sv
// instr_exec: mode-1 execute stage. Runs a fetch/decode/execute FSM over an
// accumulator datapath, returns pc_ena to the PC stage and emits results on a
// valid/ready OUT port.
// Optional feature macro: EXEC_FLAGS_EN (zero/carry flags and the SKZ skip).
// Without it the flag outputs are tied low and opcode D behaves as NOP.
//
// state    | meaning
// ---------+------------------------------------------------------------
// FETCH    | capture instr into ir
// DECODE   | split ir into opcode and zero-extended immediate
// EXEC     | apply the op; pc_ena unless OUT/HALT
// OUT_WAIT | payload held valid until consumer accepts it
// SKIP     | second pc_ena of a taken SKZ (flags build only)
// HALT     | terminal until reset
module instr_exec #(
    parameter int              DW        = 8,
    parameter logic [DW-1:0]   RESET_ACC = '0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ena,
    input  logic [7:0]    instr,
    output logic          pc_ena,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] acc,
    output logic          zero_f,
    output logic          carry_f,
    output logic          halted
);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_OUT_WAIT, S_SKIP, S_HALT
    } state_t;

    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_ADDI = 4'h2;
    localparam logic [3:0] OP_SUBI = 4'h3;
    localparam logic [3:0] OP_ANDI = 4'h4;
    localparam logic [3:0] OP_ORI  = 4'h5;
    localparam logic [3:0] OP_XORI = 4'h6;
    localparam logic [3:0] OP_MOVB = 4'h7;
    localparam logic [3:0] OP_ADDB = 4'h8;
    localparam logic [3:0] OP_SUBB = 4'h9;
    localparam logic [3:0] OP_SHL  = 4'hA;
    localparam logic [3:0] OP_SHR  = 4'hB;
    localparam logic [3:0] OP_OUT  = 4'hC;
    localparam logic [3:0] OP_SKZ  = 4'hD;
    localparam logic [3:0] OP_HALT = 4'hF;

    state_t        state, state_nxt;
    logic [7:0]    ir;
    logic [3:0]    op;
    logic [DW-1:0] imm;
    logic [DW-1:0] b;
    logic [DW-1:0] operand;
    logic [DW-1:0] add_r, sub_r;
    logic [DW-1:0] alu_res;
    logic          acc_we;
    logic          skz_take;

    assign operand = (op == OP_ADDB || op == OP_SUBB) ? b : imm;
    assign halted  = (state == S_HALT);

`ifdef EXEC_FLAGS_EN
    logic add_c, sub_c;
    logic zf, cf;
    logic flag_we, alu_c;

    // carry out of the top bit for ADD, borrow (acc < operand) for SUB
    assign {add_c, add_r} = {1'b0, acc} + {1'b0, operand};
    assign {sub_c, sub_r} = {1'b0, acc} - {1'b0, operand};
    assign zero_f   = zf;
    assign carry_f  = cf;
    assign skz_take = zf;

    // flag update selection per opcode
    always_comb begin
        flag_we = 1'b1;
        alu_c   = 1'b0;
        case (op)
            OP_ADDI, OP_ADDB: alu_c = add_c;
            OP_SUBI, OP_SUBB: alu_c = sub_c;
            OP_SHL:           alu_c = acc[DW-1];
            OP_SHR:           alu_c = acc[0];
            OP_LDI, OP_ANDI, OP_ORI, OP_XORI: alu_c = 1'b0;
            default:          flag_we = 1'b0;
        endcase
    end

    // flag registers, written only when an arithmetic/logic op executes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            zf <= 1'b0;
            cf <= 1'b0;
        end else if (ena && state == S_EXEC && flag_we) begin
            zf <= (alu_res == '0);
            cf <= alu_c;
        end
    end
`else
    assign add_r    = acc + operand;
    assign sub_r    = acc - operand;
    assign zero_f   = 1'b0;
    assign carry_f  = 1'b0;
    assign skz_take = 1'b0;
`endif

    // accumulator result for the current opcode
    always_comb begin
        alu_res = acc;
        acc_we  = 1'b1;
        case (op)
            OP_LDI:           alu_res = imm;
            OP_ADDI, OP_ADDB: alu_res = add_r;
            OP_SUBI, OP_SUBB: alu_res = sub_r;
            OP_ANDI:          alu_res = acc & imm;
            OP_ORI:           alu_res = acc | imm;
            OP_XORI:          alu_res = acc ^ imm;
            OP_SHL:           alu_res = {acc[DW-2:0], 1'b0};
            OP_SHR:           alu_res = {1'b0, acc[DW-1:1]};
            default:          acc_we  = 1'b0;
        endcase
    end

    // next-state and pc_ena; with ena low nothing moves
    always_comb begin
        state_nxt = state;
        pc_ena    = 1'b0;
        if (ena) begin
            case (state)
                S_FETCH:  state_nxt = S_DECODE;
                S_DECODE: state_nxt = S_EXEC;
                S_EXEC: begin
                    case (op)
                        OP_OUT:  state_nxt = S_OUT_WAIT;
                        OP_HALT: state_nxt = S_HALT;
                        OP_SKZ: begin
                            pc_ena    = 1'b1;
                            state_nxt = skz_take ? S_SKIP : S_FETCH;
                        end
                        default: begin
                            pc_ena    = 1'b1;
                            state_nxt = S_FETCH;
                        end
                    endcase
                end
                S_OUT_WAIT: begin
                    if (out_ready) begin
                        pc_ena    = 1'b1;
                        state_nxt = S_FETCH;
                    end
                end
                S_SKIP: begin
                    pc_ena    = 1'b1;
                    state_nxt = S_FETCH;
                end
                S_HALT:   state_nxt = S_HALT;
                default:  state_nxt = S_FETCH;
            endcase
        end
    end

    // state and datapath registers, all frozen while ena is low
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_FETCH;
            ir        <= '0;
            op        <= '0;
            imm       <= '0;
            acc       <= RESET_ACC;
            b         <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (ena) begin
            state <= state_nxt;
            case (state)
                S_FETCH:  ir <= instr;
                S_DECODE: begin
                    op  <= ir[7:4];
                    imm <= {{(DW-4){1'b0}}, ir[3:0]};
                end
                S_EXEC: begin
                    if (acc_we)
                        acc <= alu_res;
                    if (op == OP_MOVB)
                        b <= acc;
                    if (op == OP_OUT) begin
                        out_data  <= acc;
                        out_valid <= 1'b1;
                    end
                end
                S_OUT_WAIT: begin
                    if (out_ready)
                        out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_exec.sv
// tb_instr_exec: directed checks of instr_exec with a small ROM/PC model.
module tb_instr_exec;
    localparam int DW = 8;
`ifdef EXEC_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          ena;
    logic [7:0]    instr;
    logic          pc_ena;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] acc;
    logic          zero_f;
    logic          carry_f;
    logic          halted;

    logic [7:0]    rom [16];
    logic [3:0]    pc;

    int errs   = 0;
    int checks = 0;

    instr_exec #(.DW(DW), .RESET_ACC('0)) dut (
        .clk(clk), .reset(reset), .ena(ena), .instr(instr), .pc_ena(pc_ena),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .acc(acc), .zero_f(zero_f), .carry_f(carry_f), .halted(halted)
    );

    always #5 clk = ~clk;

    assign instr = rom[pc];

    always @(posedge clk or posedge reset) begin
        if (reset) pc <= 4'd0;
        else if (pc_ena) pc <= pc + 4'd1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 16; i++) rom[i] = 8'hF0;
    endtask

    // leaves the bench at the negedge where the DUT sits in FETCH (cycle 0)
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        ena   = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run_mask(input int nc, output logic [31:0] pm, output logic [31:0] vm);
        pm = '0;
        vm = '0;
        for (int c = 0; c < nc; c++) begin
            #1;
            pm[c] = pc_ena;
            vm[c] = out_valid;
            @(negedge clk);
        end
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        #1;
        while (!out_valid && n < 60) begin
            @(negedge clk);
            #1;
            n++;
        end
        check(tag, {31'd0, out_valid}, 32'd1);
    endtask

    initial begin
        logic [31:0] pm, vm;
        int vcnt, bad, pcnt_ow, pcnt, cnt;

        reset = 1'b1; ena = 1'b1; out_ready = 1'b0;
        clear_rom();

        // T1: reset state, then reset mid-DECODE and mid-OUT_WAIT
        rom[0] = 8'h15; rom[1] = 8'hC0;
        do_reset();
        #1;
        check("t1_acc_rst",   acc,       32'h0);
        check("t1_valid_rst", out_valid, 32'h0);
        check("t1_halt_rst",  halted,    32'h0);
        check("t1_pcena_c0",  pc_ena,    32'h0);
        check("t1_zf_rst",    zero_f,    32'h0);
        check("t1_cf_rst",    carry_f,   32'h0);
        repeat (3) @(negedge clk);
        #1 check("t1_acc_ldi", acc, 32'h05);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("t1_acc_mid_dec", acc,       32'h0);
        check("t1_vld_mid_dec", out_valid, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        run_mask(3, pm, vm);
        check("t1_pcena_after", pm[2:0], 32'b100);
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1 check("t1_out_pending", out_valid, 32'h1);
        reset = 1'b1;
        #1 check("t1_out_dropped", out_valid, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // T2: LDI 5, ADDI 3, OUT with out_ready high, then HALT
        clear_rom();
        rom[0] = 8'h15; rom[1] = 8'h23; rom[2] = 8'hC0;
        out_ready = 1'b1;
        do_reset();
        run_mask(14, pm, vm);
        check("t2_pcena_mask", pm & 32'h0FFF, 32'h224);
        check("t2_valid_mask", vm & 32'h0FFF, 32'h200);
        check("t2_out_data",   out_data, 32'h08);
        #1 check("t2_halted",  halted,   32'h1);

        // T3: OUT held 6 cycles while out_ready is low for 5
        clear_rom();
        rom[0] = 8'h19; rom[1] = 8'hC0; rom[2] = 8'h11;
        out_ready = 1'b0;
        do_reset();
        vcnt = 0; bad = 0; pcnt_ow = 0; pcnt = 0;
        for (int c = 0; c < 16; c++) begin
            out_ready = (c >= 11);
            #1;
            if (out_valid) begin
                vcnt++;
                if (out_data !== 8'h09) bad++;
            end
            if (pc_ena) begin
                pcnt++;
                if (c >= 6 && c <= 11) pcnt_ow++;
            end
            @(negedge clk);
        end
        check("t3_valid_cycles", vcnt,    32'd6);
        check("t3_data_stable",  bad,     32'd0);
        check("t3_pcena_ow",     pcnt_ow, 32'd1);
        check("t3_pcena_total",  pcnt,    32'd3);
        #1 check("t3_acc_final", acc,     32'h01);

        // T4: wrap up to 0x10 and borrow down to 0xFF
        clear_rom();
        rom[0] = 8'h1F; rom[1] = 8'h21; rom[2] = 8'hC0;
        rom[3] = 8'h10; rom[4] = 8'h31; rom[5] = 8'hC0;
        out_ready = 1'b1;
        do_reset();
        wait_valid("t4a_valid");
        check("t4a_data", out_data, 32'h10);
        check("t4a_cf",   carry_f,  32'h0);
        check("t4a_zf",   zero_f,   32'h0);
        @(negedge clk);
        wait_valid("t4b_valid");
        check("t4b_data", out_data, 32'hFF);
        check("t4b_acc",  acc,      32'hFF);
        check("t4b_cf",   carry_f,  {31'd0, FLAGS});
        check("t4b_zf",   zero_f,   32'h0);

        // T5: SKZ after LDI 0 skips LDI 7 (flags build); NOP otherwise
        clear_rom();
        rom[0] = 8'h10; rom[1] = 8'hD0; rom[2] = 8'h17; rom[3] = 8'hC0;
        out_ready = 1'b1;
        do_reset();
        run_mask(14, pm, vm);
        check("t5_pcena_mask", pm & 32'h3FFF, FLAGS ? 32'h464 : 32'h1124);
        check("t5_out_data",   out_data,      FLAGS ? 32'h00 : 32'h07);
        #1 check("t5_zf",      zero_f,        {31'd0, FLAGS});

        // T6: HALT is sticky through ena toggling
        clear_rom();
        rom[0] = 8'h1A; rom[1] = 8'hF0; rom[2] = 8'h13;
        out_ready = 1'b1;
        do_reset();
        repeat (8) @(negedge clk);
        #1;
        check("t6_halted", halted, 32'h1);
        check("t6_acc",    acc,    32'h0A);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            ena = i[0];
            #1;
            if (pc_ena) cnt++;
            @(negedge clk);
        end
        ena = 1'b1;
        #1;
        check("t6_pcena_cnt", cnt,    32'd0);
        check("t6_acc_hold",  acc,    32'h0A);
        check("t6_still_hlt", halted, 32'h1);
        check("t6_pc",        pc,     32'h1);
        reset = 1'b1;
        #1;
        check("t6_rst_halt", halted, 32'h0);
        check("t6_rst_acc",  acc,    32'h0);
        @(negedge clk);
        reset = 1'b0;

        // T7: ena low during EXEC freezes the op and pc_ena
        clear_rom();
        rom[0] = 8'h16; rom[1] = 8'hC0;
        out_ready = 1'b1;
        do_reset();
        repeat (2) @(negedge clk);
        ena = 1'b0;
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (pc_ena) cnt++;
            if (acc !== 8'h00) cnt++;
            @(negedge clk);
        end
        check("t7_frozen", cnt, 32'd0);
        ena = 1'b1;
        #1 check("t7_pcena_resume", pc_ena, 32'h1);
        @(negedge clk);
        #1 check("t7_acc", acc, 32'h06);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
